// File: rtl/rv_pkg.sv
// Shared RV32I constants for the fetch front end.
package rv_pkg;
  localparam int          XLEN     = 32;
  localparam int          IADDR_W  = 30;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Debug/loader read port that time-shares the instruction ROM with fetch.
interface if_fetch_ctrl_if;
  import rv_pkg::*;
  logic               dbg_req_i;
  logic [IADDR_W-1:0] dbg_addr_i;
  logic               dbg_gnt_o;
  logic               dbg_rvalid_o;
  logic [XLEN-1:0]    dbg_rdata_o;

  modport master (output dbg_req_i, dbg_addr_i, input dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o);
  modport slave  (input dbg_req_i, dbg_addr_i, output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o);
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, arbitrates the ROM port between
// fetch and debug reads, and holds the IF/ID pipeline register.
module if_fetch_ctrl
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  if_fetch_ctrl_if.slave     dbg,
  output logic [IADDR_W-1:0] rom_addr_o,
  input  logic [XLEN-1:0]    rom_inst_i,
  output logic [XLEN-1:0]    if_pc_o,
  output logic [XLEN-1:0]    if_inst_o,
  output logic               if_valid_o,
  output logic               misalign_o,
  output logic [CNT_W-1:0]   fetch_cnt_o
);

  logic [XLEN-1:0] pc;
  logic            dbg_last;
  logic            gnt;

  // Debug may not take two free-running cycles in a row; stalled cycles are idle anyway.
  assign gnt           = dbg.dbg_req_i & ~redirect_i & (stall_i | ~dbg_last);
  assign dbg.dbg_gnt_o = gnt;
  assign rom_addr_o    = gnt ? dbg.dbg_addr_i : pc[XLEN-1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc               <= RESET_PC;
      if_pc_o          <= '0;
      if_inst_o        <= NOP_INST;
      if_valid_o       <= 1'b0;
      misalign_o       <= 1'b0;
      fetch_cnt_o      <= '0;
      dbg_last         <= 1'b0;
      dbg.dbg_rvalid_o <= 1'b0;
      dbg.dbg_rdata_o  <= '0;
    end else begin
      misalign_o       <= 1'b0;
      dbg_last         <= gnt & ~stall_i;
      dbg.dbg_rvalid_o <= gnt;
      if (gnt) dbg.dbg_rdata_o <= rom_inst_i;

      if (redirect_i) begin
        pc         <= {redirect_pc_i[XLEN-1:2], 2'b00};
        if_valid_o <= 1'b0;
        if_inst_o  <= NOP_INST;
        misalign_o <= |redirect_pc_i[1:0];
      end else if (stall_i) begin
        pc <= pc;
      end else if (gnt) begin
        if_valid_o <= 1'b0;
        if_inst_o  <= NOP_INST;
      end else begin
        if_pc_o     <= pc;
        if_inst_o   <= rom_inst_i;
        if_valid_o  <= 1'b1;
        pc          <= pc + 32'd4;
        fetch_cnt_o <= fetch_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Randomized scoreboard bench for if_fetch_ctrl against a transaction-level model.
module tb_if_fetch_ctrl;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0, redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [29:0] rom_addr_o;
  logic [31:0] rom_inst_i, if_pc_o, if_inst_o;
  logic        if_valid_o, misalign_o;
  logic [15:0] fetch_cnt_o;

  if_fetch_ctrl_if dbg();

  if_fetch_ctrl #(.RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .dbg(dbg), .rom_addr_o(rom_addr_o),
    .rom_inst_i(rom_inst_i), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o),
    .if_valid_o(if_valid_o), .misalign_o(misalign_o), .fetch_cnt_o(fetch_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [29:0] a);
    case (a)
      30'd0:   rom_fn = 32'h0000_0013;
      30'd1:   rom_fn = 32'h0000_0013;
      30'd2:   rom_fn = 32'h0000_0293;
      30'd3:   rom_fn = 32'h0010_0313;
      30'd6:   rom_fn = 32'hFE02_9CE3;
      default: rom_fn = ({2'b00, a} * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endcase
  endfunction
  assign rom_inst_i = rom_fn(rom_addr_o);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural view of the fetch stage.
  logic [31:0] m_pc, m_ifpc, m_inst, m_rdata;
  logic        m_valid, m_mis, m_rvalid, m_dbg_prev_free;
  int          m_cnt;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } fetch_t;
  fetch_t      fetch_q[$];
  logic [31:0] dbg_q[$];

  task automatic model_reset();
    m_pc = 32'h0; m_ifpc = 32'h0; m_inst = NOP_INST; m_valid = 0; m_mis = 0;
    m_rvalid = 0; m_rdata = 0; m_cnt = 0; m_dbg_prev_free = 0;
    fetch_q.delete(); dbg_q.delete();
  endtask

  task automatic check_state();
    chk("if_pc", if_pc_o, m_ifpc);
    chk("if_inst", if_inst_o, m_inst);
    chk("if_valid", {31'b0, if_valid_o}, {31'b0, m_valid});
    chk("misalign", {31'b0, misalign_o}, {31'b0, m_mis});
    chk("fetch_cnt", {16'b0, fetch_cnt_o}, m_cnt & 32'hFFFF);
    chk("dbg_rvalid", {31'b0, dbg.dbg_rvalid_o}, {31'b0, m_rvalid});
    chk("dbg_rdata", dbg.dbg_rdata_o, m_rdata);
  endtask

  // Called at a negedge: drive, check the port decision, advance model, wait one clock.
  task automatic cycle(input logic s, input logic r, input logic [31:0] rp,
                       input logic q, input logic [29:0] a);
    logic grant;
    stall_i = s; redirect_i = r; redirect_pc_i = rp;
    dbg.dbg_req_i = q; dbg.dbg_addr_i = a;
    #1;
    grant = q && !r && (s || !m_dbg_prev_free);
    chk("dbg_gnt", {31'b0, dbg.dbg_gnt_o}, {31'b0, grant});
    chk("rom_addr", {2'b0, rom_addr_o}, grant ? {2'b0, a} : {2'b0, m_pc[31:2]});
    m_rvalid = grant;
    if (grant) begin
      m_rdata = rom_fn(a);
      dbg_q.push_back(m_rdata);
    end
    m_mis = r && (rp[1:0] != 2'b00);
    if (r) begin
      m_pc = rp & 32'hFFFF_FFFC; m_valid = 0; m_inst = NOP_INST;
    end else if (s) begin
      // IF/ID and PC frozen
    end else if (grant) begin
      m_valid = 0; m_inst = NOP_INST;
    end else begin
      fetch_q.push_back('{pc: m_pc, inst: rom_fn(m_pc[31:2])});
      m_ifpc = m_pc; m_inst = rom_fn(m_pc[31:2]); m_valid = 1;
      m_pc = m_pc + 32'd4; m_cnt = m_cnt + 1;
    end
    m_dbg_prev_free = grant && !s;
    @(negedge clk);
    check_state();
  endtask

  // Monitor: pops expected transactions whenever the DUT presents a new result.
  initial begin
    logic [15:0] prev_cnt;
    fetch_t      f;
    logic [31:0] d;
    prev_cnt = 16'h0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        if (dbg.dbg_rvalid_o) begin
          if (dbg_q.size() == 0) chk("sb_dbg_unexpected", 32'h1, 32'h0);
          else begin
            d = dbg_q.pop_front();
            chk("sb_dbg_rdata", dbg.dbg_rdata_o, d);
          end
        end
        if (dbg_q.size() != 0) begin
          chk("sb_dbg_missing", dbg_q.size(), 32'h0);
          dbg_q.delete();
        end
        if (fetch_cnt_o != prev_cnt) begin
          if (fetch_q.size() == 0) chk("sb_fetch_unexpected", 32'h1, 32'h0);
          else begin
            f = fetch_q.pop_front();
            chk("sb_fetch_pc", if_pc_o, f.pc);
            chk("sb_fetch_inst", if_inst_o, f.inst);
            chk("sb_fetch_valid", {31'b0, if_valid_o}, 32'h1);
          end
        end
        if (fetch_q.size() != 0) begin
          chk("sb_fetch_missing", fetch_q.size(), 32'h0);
          fetch_q.delete();
        end
      end
      prev_cnt = fetch_cnt_o;
    end
  end

  initial begin
    logic [31:0] rp;
    dbg.dbg_req_i = 1'b0; dbg.dbg_addr_i = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_state();

    // Straight-line fetch, then a 3-cycle stall at pc=8
    repeat (2) cycle(0, 0, 0, 0, 0);
    repeat (3) cycle(1, 0, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 0);
    // Redirect overriding stall, then a misaligned target
    cycle(1, 1, 32'h10, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 32'h13, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 0);
    // Debug reads with and without stall, and blocked by redirect
    repeat (4) cycle(0, 0, 0, 1, 30'd6);
    repeat (3) cycle(1, 0, 0, 1, 30'd6);
    cycle(1, 1, 32'h40, 1, 30'd6);
    cycle(0, 0, 0, 0, 0);
    // PC wrap
    cycle(0, 1, 32'hFFFF_FFFC, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 9))
        0:       rp = 32'hFFFF_FFF8 | ($urandom & 32'h7);
        default: rp = $urandom_range(0, 1023);
      endcase
      cycle($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, rp,
            $urandom_range(0, 9) < 4, 30'($urandom_range(0, 63)));
    end

    // Async reset while a debug read is returning data
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 30'd6);
    chk("pre_rst_rvalid", {31'b0, dbg.dbg_rvalid_o}, 32'h1);
    rst = 1'b1;
    #1;
    chk("async_rst_rvalid", {31'b0, dbg.dbg_rvalid_o}, 32'h0);
    chk("async_rst_valid", {31'b0, if_valid_o}, 32'h0);
    model_reset();
    check_state();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) cycle(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1);
  end
endmodule
